// File: rtl/tech_rff_pkg.sv
// Shared helpers for the elastic register pipeline: width functions and edge-select constants.
package tech_rff_pkg;

    localparam bit EDGE_POS = 1'b0;
    localparam bit EDGE_NEG = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        int r;
        r = clog2(depth + 1);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tech_rff_if.sv
// Handshake bundle for tech_rff_pipe: upstream/downstream valid-ready, flush and occupancy.
interface tech_rff_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    import tech_rff_pkg::*;

    localparam int CNT_W = cnt_w(DEPTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/tech_rff_stage.sv
// One {valid,data} pipeline stage. Clear wins over load and leaves the data register untouched.
module tech_rff_stage
    import tech_rff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               NEG_EDGE = EDGE_POS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    logic             v_nxt;
    logic [WIDTH-1:0] d_nxt;

    always_comb begin
        v_nxt = v_q;
        d_nxt = d_q;
        if (clear) begin
            v_nxt = 1'b0;
        end else if (load) begin
            v_nxt = 1'b1;
            d_nxt = d_in;
        end else if (drain) begin
            v_nxt = 1'b0;
        end
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk) begin
            if (!reset) begin
                v_q <= 1'b0;
                d_q <= RST_VAL;
            end else begin
                v_q <= v_nxt;
                d_q <= d_nxt;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk) begin
            if (!reset) begin
                v_q <= 1'b0;
                d_q <= RST_VAL;
            end else begin
                v_q <= v_nxt;
                d_q <= d_nxt;
            end
        end
    end

endmodule

// File: rtl/tech_rff_pipe.sv
// WIDTH x DEPTH elastic register pipeline with bubble collapsing, flush and occupancy count.
module tech_rff_pipe
    import tech_rff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               NEG_EDGE = EDGE_POS
) (
    input logic       clk,
    input logic       reset,
    tech_rff_if.slave bus
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH:0]   v_x;
    logic [DEPTH:0]   adv_x;
    logic [WIDTH-1:0] d [DEPTH];
    logic             accept;
    logic             deliver;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // The sink is modelled as an always-valid stage that advances with out_ready.
    assign v_x = {1'b1, v};

    always_comb begin
        adv_x        = '0;
        adv_x[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv_x[i] = v_x[i] & (~v_x[i+1] | adv_x[i+1]);
        end
    end

    assign bus.in_ready = ~v[0] | adv_x[0];
    assign accept       = bus.in_valid & bus.in_ready;
    assign deliver      = adv_x[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             ld;
        logic [WIDTH-1:0] din;

        if (g == 0) begin : g_head
            assign ld  = accept;
            assign din = bus.in_data;
        end else begin : g_body
            assign ld  = adv_x[g-1];
            assign din = d[g-1];
        end

        tech_rff_stage #(
            .WIDTH    (WIDTH),
            .RST_VAL  (RST_VAL),
            .NEG_EDGE (NEG_EDGE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clear (bus.flush),
            .load  (ld),
            .drain (adv_x[g]),
            .d_in  (din),
            .v_q   (v[g]),
            .d_q   (d[g])
        );
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (bus.flush) begin
            cnt_nxt = '0;
        end else if (accept && !deliver) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else if (!accept && deliver) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    if (NEG_EDGE) begin : g_cnt_neg
        always_ff @(negedge clk) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_nxt;
        end
    end else begin : g_cnt_pos
        always_ff @(posedge clk) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_nxt;
        end
    end

    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_tech_rff_pipe.sv
// Bench for tech_rff_pipe: posedge and negedge instances checked against a word-level model.
module tb_tech_rff_pipe;
    import tech_rff_pkg::*;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         CW = cnt_w(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst, s_fl, s_iv, s_ordy;
    logic [7:0] s_id;

    tech_rff_if #(.WIDTH(W), .DEPTH(D)) if_p ();
    tech_rff_if #(.WIDTH(W), .DEPTH(D)) if_n ();

    assign if_p.flush = s_fl;  assign if_p.in_valid = s_iv;
    assign if_p.in_data = s_id; assign if_p.out_ready = s_ordy;
    assign if_n.flush = s_fl;  assign if_n.in_valid = s_iv;
    assign if_n.in_data = s_id; assign if_n.out_ready = s_ordy;

    tech_rff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV), .NEG_EDGE(EDGE_POS)) dut_p (
        .clk(clk), .reset(s_rst), .bus(if_p));
    tech_rff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV), .NEG_EDGE(EDGE_NEG)) dut_n (
        .clk(clk), .reset(s_rst), .bus(if_n));

    int sel = 0;
    int checks = 0;
    int errors = 0;

    logic          o_ir, o_ov;
    logic [7:0]    o_od;
    logic [CW-1:0] o_cnt;

    always_comb begin
        if (sel == 0) begin
            o_ir = if_p.in_ready; o_ov = if_p.out_valid; o_od = if_p.out_data; o_cnt = if_p.count;
        end else begin
            o_ir = if_n.in_ready; o_ov = if_n.out_valid; o_od = if_n.out_data; o_cnt = if_n.count;
        end
    end

    // Reference model: words in flight with their stage position, oldest first.
    typedef struct {
        logic [7:0] d;
        int         pos;
    } word_t;

    word_t      q[$];
    logic [7:0] rx[$];
    logic [7:0] last_out = RV;

    task automatic wait_active();
        if (sel == 0) @(posedge clk); else @(negedge clk);
    endtask

    task automatic wait_inactive();
        if (sel == 0) @(negedge clk); else @(posedge clk);
    endtask

    task automatic step(input bit rst, input bit fl, input bit iv, input logic [7:0] id, input bit ordy);
        bit exp_ir, acc, dlv, exp_ov;
        int lim;
        word_t w;
        s_rst = rst; s_fl = fl; s_iv = iv; s_id = id; s_ordy = ordy;
        #1;
        exp_ir = (q.size() < D) || ordy;
        checks++;
        if (o_ir !== exp_ir) begin
            errors++; $display("FAIL in_ready: got %b expected %b t=%0t", o_ir, exp_ir, $time);
        end
        acc = iv && exp_ir;
        dlv = (q.size() > 0) && (q[0].pos == D - 1) && ordy;
        wait_inactive();
        #1;
        checks++;
        if (o_cnt !== CW'(q.size())) begin
            errors++; $display("FAIL count_inactive_edge: got %0d expected %0d t=%0t", o_cnt, q.size(), $time);
        end
        wait_active();
        if (!rst) begin
            q.delete();
            last_out = RV;
        end else if (fl) begin
            if (dlv) rx.push_back(q[0].d);
            q.delete();
        end else begin
            if (dlv) begin
                rx.push_back(q[0].d);
                void'(q.pop_front());
            end
            lim = D - 1;
            for (int k = 0; k < q.size(); k++) begin
                w = q[k];
                w.pos = (w.pos + 1 < lim) ? w.pos + 1 : lim;
                lim = w.pos - 1;
                q[k] = w;
            end
            if (acc) begin
                w.d = id; w.pos = 0;
                q.push_back(w);
            end
            if (q.size() > 0 && q[0].pos == D - 1) last_out = q[0].d;
        end
        #1;
        exp_ov = (q.size() > 0) && (q[0].pos == D - 1);
        checks++;
        if (o_ov !== exp_ov) begin
            errors++; $display("FAIL out_valid: got %b expected %b t=%0t", o_ov, exp_ov, $time);
        end
        checks++;
        if (o_od !== last_out) begin
            errors++; $display("FAIL out_data: got %h expected %h t=%0t", o_od, last_out, $time);
        end
        checks++;
        if (o_cnt !== CW'(q.size())) begin
            errors++; $display("FAIL count: got %0d expected %0d t=%0t", o_cnt, q.size(), $time);
        end
    endtask

    task automatic switch_to(input int n);
        s_rst = 1'b0; s_fl = 1'b0; s_iv = 1'b0; s_ordy = 1'b0; s_id = 8'h00;
        repeat (2) @(negedge clk);
        sel = n;
        q.delete();
        rx.delete();
        last_out = RV;
        if (n == 0) @(posedge clk); else @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", o_ov); end
        checks++; if (o_od !== 8'hA5) begin errors++; $display("FAIL reset_out_data: got %h expected a5", o_od); end
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_cnt); end
        checks++; if (o_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", o_ir); end
    endtask

    task automatic test_stream();
        int first_ov;
        first_ov = -1;
        step(0, 0, 0, 8'h00, 1);
        rx.delete();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_ir !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b expected 1 word %0d", o_ir, i + 1); end
            step(1, 0, 1, 8'(i + 1), 1);
            if (o_ov === 1'b1 && first_ov < 0) first_ov = i + 1;
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 1);
        checks++;
        if (first_ov != D) begin errors++; $display("FAIL stream_latency: got %0d edges expected %0d", first_ov, D); end
        checks++;
        if (rx.size() != 10) begin errors++; $display("FAIL stream_count: got %0d words expected 10", rx.size()); end
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_order: got %h expected %h", rx[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 8'h00, 0);
        rx.delete();
        for (int i = 0; i < 6; i++) step(1, 0, 1, 8'(8'h10 + i), 0);
        checks++; if (o_cnt !== CW'(4)) begin errors++; $display("FAIL stall_full_count: got %0d expected 4", o_cnt); end
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", o_ir); end
        step(1, 0, 1, 8'h20, 1);
        checks++; if (o_cnt !== CW'(4)) begin errors++; $display("FAIL stall_swap_count: got %0d expected 4", o_cnt); end
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h10) begin
            errors++; $display("FAIL stall_swap_word: got %0d words expected one word 10", rx.size());
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 1);
    endtask

    task automatic test_bubble();
        step(0, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h3C, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL bubble_early: got %b expected 0", o_ov); end
        step(1, 0, 0, 8'h00, 0);
        checks++; if (o_ov !== 1'b1) begin errors++; $display("FAIL bubble_arrive: got %b expected 1", o_ov); end
        checks++; if (o_cnt !== CW'(1)) begin errors++; $display("FAIL bubble_count: got %0d expected 1", o_cnt); end
        step(1, 0, 0, 8'h00, 1);
    endtask

    task automatic test_flush();
        step(0, 0, 0, 8'h00, 0);
        rx.delete();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(8'h51 + i), 0);
        step(1, 1, 1, 8'h77, 0);
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", o_cnt); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", o_ov); end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 1);
        checks++;
        if (rx.size() != 0) begin errors++; $display("FAIL flush_leak: got %0d words expected 0", rx.size()); end
        checks++; if (o_od === 8'h77) begin errors++; $display("FAIL flush_dropped_word: got %h expected not 77", o_od); end
    endtask

    task automatic test_midreset();
        step(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 8'(8'h60 + i), 1);
        step(0, 0, 1, 8'h99, 1);
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", o_cnt); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", o_ov); end
        checks++; if (o_od !== RV) begin errors++; $display("FAIL midreset_out_data: got %h expected a5", o_od); end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 1);
    endtask

    task automatic test_random(input int n);
        bit rst, fl, iv, ordy;
        for (int i = 0; i < n; i++) begin
            rst  = ($urandom_range(0, 99) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            step(rst, fl, iv, 8'($urandom_range(0, 255)), ordy);
        end
    endtask

    initial begin
        switch_to(0);
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
        test_random(400);

        switch_to(1);
        test_reset();
        test_stream();
        test_midreset();
        test_stall();
        test_random(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
